// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O port bank: per-channel output latches with strobes and
// per-channel input FIFOs, overlaid on the data-memory address space.

module mmio_port_chan #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sel,
   input  logic             wr,
   input  logic             rd,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_valid,
   output logic             ready,
   output logic [WIDTH-1:0] head,
   output logic             nonempty,
   output logic             full,
   output logic [WIDTH-1:0] out_data,
   output logic             out_strobe
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      count;
   logic             push, pop;

   assign nonempty = (count != '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign ready    = ~full;
   assign push     = push_valid & ~full;
   assign pop      = sel & rd & nonempty;
   assign head     = nonempty ? mem[rp] : '0;

   // Storage is never cleared; it is unobservable while the FIFO is empty.
   always_ff @(posedge clock)
      if (push) mem[wp] <= push_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_data   <= '0;
         out_strobe <= 1'b0;
      end else begin
         out_strobe <= sel & wr;
         if (sel & wr) out_data <= wr_data;
      end
   end
endmodule

module mmio_port_bank #(
   parameter int          WIDTH    = 16,
   parameter int          CHANNELS = 4,
   parameter int          DEPTH    = 4,
   parameter int unsigned IO_BASE  = 'h00F8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      mem_write,
   input  logic                      mem_read,
   input  logic [WIDTH-1:0]          mem_rdata,
   output logic                      mem_write_out,
   output logic [WIDTH-1:0]          rd_data,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_strobe
);
   logic [CHANNELS-1:0]            ch_sel, nonempty, full;
   logic [CHANNELS-1:0][WIDTH-1:0] heads, outs;
   logic                           stat_sel;
   logic [WIDTH-1:0]               status;

   assign stat_sel      = (addr == WIDTH'(IO_BASE + CHANNELS));
   assign mem_write_out = mem_write & ~(|ch_sel | stat_sel);
   assign out_data      = outs;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign ch_sel[k] = (addr == WIDTH'(IO_BASE + k));

      mmio_port_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
         .clock      (clock),
         .reset      (reset),
         .sel        (ch_sel[k]),
         .wr         (mem_write),
         .rd         (mem_read),
         .wr_data    (wr_data),
         .push_data  (in_data[k*WIDTH +: WIDTH]),
         .push_valid (in_valid[k]),
         .ready      (in_ready[k]),
         .head       (heads[k]),
         .nonempty   (nonempty[k]),
         .full       (full[k]),
         .out_data   (outs[k]),
         .out_strobe (out_strobe[k])
      );
   end

   always_comb begin
      status                         = '0;
      status[CHANNELS-1:0]           = nonempty;
      status[2*CHANNELS-1:CHANNELS]  = full;
   end

   always_comb begin
      rd_data = mem_rdata;
      if (stat_sel) rd_data = status;
      for (int k = 0; k < CHANNELS; k++)
         if (ch_sel[k]) rd_data = heads[k];
   end
endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank (default parameters).

module tb_mmio_port_bank;
   logic        clock = 0;
   logic        reset = 1;
   logic [15:0] addr = 0, wr_data = 0, mem_rdata = 0;
   logic        mem_write = 0, mem_read = 0;
   logic        mem_write_out;
   logic [15:0] rd_data;
   logic [63:0] in_data = 0;
   logic [3:0]  in_valid = 0, in_ready, out_strobe;
   logic [63:0] out_data;

   int checks = 0, failures = 0;
   logic [15:0] got;

   localparam logic [15:0] STAT = 16'h00FC;

   mmio_port_bank dut (
      .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
      .mem_write_out(mem_write_out), .rd_data(rd_data),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_strobe(out_strobe)
   );

   always #5 clock = ~clock;

   // Stimulus helpers (no checking inside).
   task automatic push(input int ch, input logic [15:0] w);
      @(negedge clock);
      in_data[ch*16 +: 16] = w;
      in_valid[ch] = 1'b1;
      @(posedge clock); #1;
      in_valid[ch] = 1'b0;
   endtask

   task automatic load(input logic [15:0] a, output logic [15:0] d);
      @(negedge clock);
      addr = a; mem_read = 1'b1;
      #1 d = rd_data;
      @(posedge clock); #1;
      mem_read = 1'b0;
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      @(negedge clock);
      addr = a; wr_data = d; mem_write = 1'b1;
      @(posedge clock); #1;
      mem_write = 1'b0;
   endtask

   task automatic peek_status(output logic [15:0] d);
      @(negedge clock);
      addr = STAT; mem_read = 1'b0;
      #1 d = rd_data;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (in_ready !== 4'b1111) begin failures++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
      checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (out_strobe !== 4'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", out_strobe); end
      @(negedge clock); reset = 0;
      peek_status(got);
      checks++; if (got !== 16'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", got); end
   endtask

   task automatic test_store_io;
      @(negedge clock);
      addr = 16'h00F9; wr_data = 16'h00A5; mem_write = 1'b1;
      #1;
      checks++; if (mem_write_out !== 1'b0) begin failures++; $display("FAIL io_store_mwo got=%b exp=0", mem_write_out); end
      checks++; if (out_strobe !== 4'b0) begin failures++; $display("FAIL io_store_early_strobe got=%b exp=0", out_strobe); end
      @(posedge clock); #1;
      mem_write = 1'b0;
      checks++; if (out_data[16 +: 16] !== 16'h00A5) begin failures++; $display("FAIL io_store_data got=%h exp=00a5", out_data[16 +: 16]); end
      checks++; if (out_strobe !== 4'b0010) begin failures++; $display("FAIL io_store_strobe got=%b exp=0010", out_strobe); end
      @(posedge clock); #1;
      checks++; if (out_strobe !== 4'b0) begin failures++; $display("FAIL io_strobe_one_cycle got=%b exp=0", out_strobe); end
      checks++; if (out_data[16 +: 16] !== 16'h00A5) begin failures++; $display("FAIL io_store_hold got=%h exp=00a5", out_data[16 +: 16]); end
   endtask

   task automatic test_store_mem;
      @(negedge clock);
      addr = 16'h0010; wr_data = 16'h1234; mem_write = 1'b1;
      #1;
      checks++; if (mem_write_out !== 1'b1) begin failures++; $display("FAIL mem_store_mwo got=%b exp=1", mem_write_out); end
      @(posedge clock); #1;
      mem_write = 1'b0;
      checks++; if (out_strobe !== 4'b0) begin failures++; $display("FAIL mem_store_strobe got=%b exp=0", out_strobe); end
      // Store to the status address is swallowed.
      @(negedge clock);
      addr = STAT; wr_data = 16'hFFFF; mem_write = 1'b1;
      #1;
      checks++; if (mem_write_out !== 1'b0) begin failures++; $display("FAIL stat_store_mwo got=%b exp=0", mem_write_out); end
      @(posedge clock); #1;
      mem_write = 1'b0;
      checks++; if (out_strobe !== 4'b0 || out_data !== 64'h0000_0000_00A5_0000) begin failures++; $display("FAIL stat_store_effect strobe=%b data=%h exp 0/00a50000", out_strobe, out_data); end
      @(negedge clock);
      addr = 16'h0010; mem_rdata = 16'hBEEF;
      #1;
      checks++; if (rd_data !== 16'hBEEF) begin failures++; $display("FAIL mem_rdata_pass got=%h exp=beef", rd_data); end
   endtask

   task automatic test_fifo_full;
      logic [15:0] exp_w [4];
      exp_w = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      for (int i = 0; i < 4; i++) push(0, exp_w[i]);
      checks++; if (in_ready !== 4'b1110) begin failures++; $display("FAIL full_in_ready got=%b exp=1110", in_ready); end
      peek_status(got);
      checks++; if (got !== 16'h0011) begin failures++; $display("FAIL full_status got=%h exp=0011", got); end
      push(0, 16'h0055);
      for (int i = 0; i < 4; i++) begin
         load(16'h00F8, got);
         checks++; if (got !== exp_w[i]) begin failures++; $display("FAIL fifo_order_%0d got=%h exp=%h", i, got, exp_w[i]); end
      end
      load(16'h00F8, got);
      checks++; if (got !== 16'h0) begin failures++; $display("FAIL empty_load got=%h exp=0", got); end
      peek_status(got);
      checks++; if (got !== 16'h0) begin failures++; $display("FAIL drained_status got=%h exp=0", got); end
   endtask

   task automatic test_push_pop;
      push(2, 16'h00AA);
      @(negedge clock);
      in_data[32 +: 16] = 16'h00BB; in_valid[2] = 1'b1;
      addr = 16'h00FA; mem_read = 1'b1;
      #1;
      checks++; if (rd_data !== 16'h00AA) begin failures++; $display("FAIL pushpop_head got=%h exp=00aa", rd_data); end
      @(posedge clock); #1;
      in_valid[2] = 1'b0; mem_read = 1'b0;
      peek_status(got);
      checks++; if (got !== 16'h0004) begin failures++; $display("FAIL pushpop_count got=%h exp=0004", got); end
      load(16'h00FA, got);
      checks++; if (got !== 16'h00BB) begin failures++; $display("FAIL pushpop_next got=%h exp=00bb", got); end
      // Push and pop on an empty FIFO: pop ignored, push lands.
      @(negedge clock);
      in_data[32 +: 16] = 16'h00CC; in_valid[2] = 1'b1;
      addr = 16'h00FA; mem_read = 1'b1;
      #1;
      checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL empty_pushpop_rd got=%h exp=0", rd_data); end
      @(posedge clock); #1;
      in_valid[2] = 1'b0; mem_read = 1'b0;
      load(16'h00FA, got);
      checks++; if (got !== 16'h00CC) begin failures++; $display("FAIL empty_pushpop_kept got=%h exp=00cc", got); end
   endtask

   task automatic test_concurrent;
      push(1, 16'h0077);
      @(negedge clock);
      addr = 16'h00F9; wr_data = 16'h5A5A; mem_write = 1'b1; mem_read = 1'b1;
      in_data[0 +: 16] = 16'h000E; in_valid[0] = 1'b1;
      #1;
      checks++; if (rd_data !== 16'h0077 || mem_write_out !== 1'b0) begin failures++; $display("FAIL conc_comb rd=%h mwo=%b exp 0077/0", rd_data, mem_write_out); end
      @(posedge clock); #1;
      mem_write = 1'b0; mem_read = 1'b0; in_valid[0] = 1'b0;
      checks++; if (out_data[16 +: 16] !== 16'h5A5A || out_strobe !== 4'b0010) begin failures++; $display("FAIL conc_store data=%h strobe=%b exp 5a5a/0010", out_data[16 +: 16], out_strobe); end
      peek_status(got);
      checks++; if (got !== 16'h0001) begin failures++; $display("FAIL conc_status got=%h exp=0001", got); end
      load(16'h00F8, got);
      checks++; if (got !== 16'h000E) begin failures++; $display("FAIL conc_ch0 got=%h exp=000e", got); end
   endtask

   task automatic test_wrap;
      int errs;
      errs = 0;
      push(1, 16'h0100);
      push(1, 16'h0101);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         in_data[16 +: 16] = 16'h0102 + 16'(i); in_valid[1] = 1'b1;
         addr = 16'h00F9; mem_read = 1'b1;
         #1 got = rd_data;
         if (got !== 16'h0100 + 16'(i)) begin errs++; $display("FAIL wrap_pair_%0d got=%h exp=%h", i, got, 16'h0100 + 16'(i)); end
         @(posedge clock); #1;
         in_valid[1] = 1'b0; mem_read = 1'b0;
      end
      checks++; if (errs != 0) failures++;
      load(16'h00F9, got);
      checks++; if (got !== 16'h010A) begin failures++; $display("FAIL wrap_drain0 got=%h exp=010a", got); end
      load(16'h00F9, got);
      checks++; if (got !== 16'h010B) begin failures++; $display("FAIL wrap_drain1 got=%h exp=010b", got); end
      peek_status(got);
      checks++; if (got !== 16'h0) begin failures++; $display("FAIL wrap_status got=%h exp=0", got); end
   endtask

   task automatic test_reset_mid;
      push(3, 16'h0301);
      push(3, 16'h0302);
      push(3, 16'h0303);
      store(16'h00F8, 16'hFFFF);
      peek_status(got);
      checks++; if (got !== 16'h0008 || out_data[0 +: 16] !== 16'hFFFF) begin failures++; $display("FAIL pre_reset status=%h ch0=%h exp 0008/ffff", got, out_data[0 +: 16]); end
      #1 reset = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b1111) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1111", in_ready); end
      checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL mid_reset_status got=%h exp=0", rd_data); end
      checks++; if (out_data !== 64'h0 || out_strobe !== 4'b0) begin failures++; $display("FAIL mid_reset_out data=%h strobe=%b exp 0/0", out_data, out_strobe); end
      @(negedge clock); reset = 1'b0;
      load(16'h00FB, got);
      checks++; if (got !== 16'h0) begin failures++; $display("FAIL post_reset_load got=%h exp=0", got); end
   endtask

   initial begin
      test_reset;
      test_store_io;
      test_store_mem;
      test_fifo_full;
      test_push_pop;
      test_concurrent;
      test_wrap;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
